// File: rtl/tpu_pkg.sv
// Shared types and helpers for the streaming convolution engine.
package tpu_pkg;

    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_KERNEL_DIM = 3;

    typedef logic signed [DEF_DATA_W-1:0] data_t;
    typedef logic signed [2*DEF_DATA_W+$clog2(DEF_KERNEL_DIM*DEF_KERNEL_DIM)-1:0] acc_t;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_e;

    // Clamp a wide signed accumulator into a dw-bit signed range.
    function automatic logic signed [31:0] sat_to_data(input logic signed [63:0] acc,
                                                       input int unsigned dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (acc > hi) begin
            return 32'(hi);
        end else if (acc < lo) begin
            return 32'(lo);
        end
        return 32'(acc);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Clear/enable multiply-accumulate with zero-tap gating and a saturated view of the next sum.
module conv_mac
    import tpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clear,
    input  logic                     zero,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] sum_c
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    base;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_next;

    // Next accumulator value: clear restarts the sum, zero drops a padded tap.
    always_comb begin
        prod     = (2*DATA_W)'(a) * (2*DATA_W)'(b);
        prod_ext = ACC_W'(prod);
        if (zero) begin
            prod_ext = '0;
        end
        base = acc;
        if (clear) begin
            base = '0;
        end
        acc_next = base + prod_ext;
        sum_c    = DATA_W'(sat_to_data(64'(acc_next), DATA_W));
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming zero-padded "same" 2D correlation engine with valid/ready on both sides.
// Optional: define CONV_RELU_EN to clamp negative saturated results to zero.
module conv_stream_engine
    import tpu_pkg::*;
#(
    parameter int unsigned MATRIX_DIM = 16,
    parameter int unsigned KERNEL_DIM = 3,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_kernel,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic              busy
);

    localparam int unsigned N     = MATRIX_DIM;
    localparam int unsigned K     = KERNEL_DIM;
    localparam int unsigned KK    = K * K;
    localparam int unsigned NN    = N * N;
    localparam int unsigned KI_W  = (KK > 1) ? $clog2(KK) : 1;
    localparam int unsigned MI_W  = $clog2(NN);
    localparam int unsigned RC_W  = $clog2(N);
    localparam int unsigned T_W   = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned ACC_W = 2 * DATA_W + $clog2(KK);
    localparam int          PAD   = int'((KERNEL_DIM - 1) / 2);
    localparam int          NS    = int'(MATRIX_DIM);
    localparam int          KS    = int'(KERNEL_DIM);

    state_e state_q, state_d;
    logic [KI_W-1:0] kidx_q, kidx_d;
    logic [MI_W-1:0] midx_q, midx_d;
    logic [RC_W-1:0] r_q, r_d, c_q, c_d;
    logic [T_W-1:0]  i_q, i_d, j_q, j_d;

    logic              in_ready_d, out_valid_d, out_last_d, done_d, busy_d;
    logic [DATA_W-1:0] out_data_d;
    logic              in_hs, kern_we, mem_we, mac_en, mac_clear, tap_zero;
    logic [MI_W-1:0]   rd_addr;
    logic [KI_W-1:0]   k_addr;

    logic signed [DATA_W-1:0] mem  [NN];
    logic signed [DATA_W-1:0] kern [KK];
    logic signed [DATA_W-1:0] mac_sum_c, result_c;

    assign in_hs = in_valid & in_ready & (state_q == LOAD);

    // Current tap coordinates; padded taps read address 0 and are gated in the MAC.
    always_comb begin
        int rr;
        int cc;
        rr       = int'(r_q) + int'(i_q) - PAD;
        cc       = int'(c_q) + int'(j_q) - PAD;
        tap_zero = (rr < 0) || (rr >= NS) || (cc < 0) || (cc >= NS);
        rd_addr  = tap_zero ? '0 : MI_W'(rr * NS + cc);
        k_addr   = KI_W'(int'(i_q) * KS + int'(j_q));
    end

    conv_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mac_en),
        .clear (mac_clear),
        .zero  (tap_zero),
        .a     (mem[rd_addr]),
        .b     (kern[k_addr]),
        .sum_c (mac_sum_c)
    );

    // Final result shaping after saturation.
    always_comb begin
`ifdef CONV_RELU_EN
        result_c = mac_sum_c[DATA_W-1] ? '0 : mac_sum_c;
`else
        result_c = mac_sum_c;
`endif
    end

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d     = state_q;
        kidx_d      = kidx_q;
        midx_d      = midx_q;
        r_d         = r_q;
        c_d         = c_q;
        i_d         = i_q;
        j_d         = j_q;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_last_d  = out_last;
        done_d      = 1'b0;
        kern_we     = 1'b0;
        mem_we      = 1'b0;
        mac_en      = 1'b0;
        mac_clear   = 1'b0;
        case (state_q)
            LOAD: begin
                if (in_hs) begin
                    if (in_kernel) begin
                        kern_we = 1'b1;
                        kidx_d  = (kidx_q == KI_W'(KK - 1)) ? '0 : kidx_q + KI_W'(1);
                    end else begin
                        mem_we = 1'b1;
                        if (midx_q == MI_W'(NN - 1)) begin
                            midx_d  = '0;
                            state_d = COMPUTE;
                        end else begin
                            midx_d = midx_q + MI_W'(1);
                        end
                    end
                end
            end
            COMPUTE: begin
                mac_en    = 1'b1;
                mac_clear = (i_q == '0) && (j_q == '0);
                if (j_q == T_W'(K - 1)) begin
                    j_d = '0;
                    if (i_q == T_W'(K - 1)) begin
                        i_d         = '0;
                        state_d     = OUTPUT;
                        out_valid_d = 1'b1;
                        out_data_d  = result_c;
                        out_last_d  = (r_q == RC_W'(N - 1)) && (c_q == RC_W'(N - 1));
                    end else begin
                        i_d = i_q + T_W'(1);
                    end
                end else begin
                    j_d = j_q + T_W'(1);
                end
            end
            OUTPUT: begin
                if (out_valid && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last) begin
                        state_d = LOAD;
                        done_d  = 1'b1;
                        r_d     = '0;
                        c_d     = '0;
                    end else begin
                        state_d = COMPUTE;
                        if (c_q == RC_W'(N - 1)) begin
                            c_d = '0;
                            r_d = r_q + RC_W'(1);
                        end else begin
                            c_d = c_q + RC_W'(1);
                        end
                    end
                end
            end
            default: state_d = LOAD;
        endcase
        in_ready_d = (state_d == LOAD);
        busy_d     = (state_d != LOAD);
    end

    // State, counters, output registers and kernel RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            kidx_q    <= '0;
            midx_q    <= '0;
            r_q       <= '0;
            c_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            for (int k = 0; k < int'(KK); k++) begin
                kern[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            kidx_q    <= kidx_d;
            midx_q    <= midx_d;
            r_q       <= r_d;
            c_q       <= c_d;
            i_q       <= i_d;
            j_q       <= j_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_last  <= out_last_d;
            done      <= done_d;
            busy      <= busy_d;
            if (kern_we) begin
                kern[kidx_q] <= in_data;
            end
        end
    end

    // Matrix RAM write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[midx_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed self-checking bench for conv_stream_engine (default N=16, K=3, DATA_W=8).
module tb_conv_stream_engine;

    localparam int N  = 16;
    localparam int KK = 9;
    localparam int NN = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_kernel = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid, out_last, done, busy;
    logic [7:0] out_data;

    int checks = 0;
    int errors = 0;
    int kmod [KK];
    int mmod [NN];
    int exp_v[NN];

    always #5 clk = ~clk;

    conv_stream_engine #(
        .MATRIX_DIM (16),
        .KERNEL_DIM (3),
        .DATA_W     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kernel (in_kernel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic k, input int v);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_kernel = k;
        in_data   = 8'(v);
        while (in_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout in_ready=%b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_kernel(input int from, input int to);
        for (int k = from; k <= to; k++) beat(1'b1, kmod[k]);
    endtask

    task automatic send_matrix(input int from, input int to);
        for (int x = from; x <= to; x++) beat(1'b0, mmod[x]);
    endtask

    function automatic int ref_pix(input int r, input int c);
        int acc;
        int rr;
        int cc;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                rr = r + i - 1;
                cc = c + j - 1;
                if (rr >= 0 && rr < N && cc >= 0 && cc < N)
                    acc += mmod[rr * N + cc] * kmod[i * 3 + j];
            end
        end
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
`ifdef CONV_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc;
    endfunction

    task automatic fill_model();
        for (int p = 0; p < NN; p++) exp_v[p] = ref_pix(p / N, p % N);
    endtask

    task automatic collect(input string name, input int stall_at);
        int         n;
        logic [7:0] hd;
        logic       hl;
        bit         stable;
        for (int p = 0; p < NN; p++) begin
            n = 0;
            while (out_valid !== 1'b1 && n < 200) begin
                step();
                n++;
            end
            if (out_valid !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout pixel %0d out_valid=%b required 1", name, p, out_valid);
                return;
            end
            if (p == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_busy got %b required 1", name, busy);
                end
            end
            if (p == stall_at) begin
                out_ready = 1'b0;
                hd = out_data;
                hl = out_last;
                stable = 1'b1;
                for (int k = 0; k < 20; k++) begin
                    step();
                    if (out_valid !== 1'b1 || out_data !== hd || out_last !== hl || in_ready !== 1'b0)
                        stable = 1'b0;
                end
                checks++;
                if (!stable) begin
                    errors++;
                    $display("FAIL %s_stall got data=%0d valid=%b in_ready=%b required data=%0d valid=1 in_ready=0",
                             name, $signed(out_data), out_valid, in_ready, $signed(hd));
                end
                out_ready = 1'b1;
            end
            checks++;
            if (out_data !== 8'(exp_v[p]) || out_last !== 1'(p == NN - 1)) begin
                errors++;
                $display("FAIL %s pixel %0d got data=%0d last=%b required data=%0d last=%b",
                         name, p, $signed(out_data), out_last, exp_v[p], p == NN - 1);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_done got done=%b busy=%b in_ready=%b required 1 0 1", name, done, busy, in_ready);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse got %b required 0", name, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({in_ready, out_valid, out_data, out_last, done, busy} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b required 0", {in_ready, out_valid, out_data, out_last, done, busy});
        end
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got in_ready=%b required 0", in_ready);
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_identity();
        for (int k = 0; k < KK; k++) kmod[k] = (k == 4) ? 1 : 0;
        for (int x = 0; x < NN; x++) mmod[x] = x % 100;
        for (int p = 0; p < NN; p++) exp_v[p] = p % 100;
        send_kernel(0, 8);
        send_matrix(0, NN - 1);
        collect("identity", -1);
    endtask

    task automatic test_ones();
        int cnt;
        int rn;
        int cn;
        for (int k = 0; k < KK; k++) kmod[k] = 1;
        for (int x = 0; x < NN; x++) mmod[x] = 1;
        for (int p = 0; p < NN; p++) begin
            rn = (p / N == 0 || p / N == N - 1) ? 2 : 3;
            cn = (p % N == 0 || p % N == N - 1) ? 2 : 3;
            exp_v[p] = rn * cn;
        end
        send_kernel(0, 8);
        send_matrix(0, NN - 1);
        cnt = 1;
        while (out_valid !== 1'b1 && cnt < 50) begin
            step();
            cnt++;
        end
        checks++;
        if (cnt != 10) begin
            errors++;
            $display("FAIL ones_latency got %0d cycles required 10", cnt);
        end
        collect("ones", -1);
    endtask

    task automatic test_saturation();
        for (int k = 0; k < KK; k++) kmod[k] = 127;
        for (int x = 0; x < NN; x++) mmod[x] = 127;
        for (int p = 0; p < NN; p++) exp_v[p] = 127;
        send_kernel(0, 8);
        send_matrix(0, NN - 1);
        collect("sat_pos", -1);
        for (int k = 0; k < KK; k++) kmod[k] = -128;
`ifdef CONV_RELU_EN
        for (int p = 0; p < NN; p++) exp_v[p] = 0;
`else
        for (int p = 0; p < NN; p++) exp_v[p] = -128;
`endif
        send_kernel(0, 8);
        send_matrix(0, NN - 1);
        collect("sat_neg", -1);
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < KK; k++) kmod[k] = (k == 4) ? 1 : 0;
        for (int x = 0; x < NN; x++) mmod[x] = x % 100;
        for (int p = 0; p < NN; p++) exp_v[p] = p % 100;
        send_kernel(0, 8);
        send_matrix(0, NN - 1);
        collect("backpressure", 5);
    endtask

    task automatic test_kernel_reload();
        kmod[4] = 2;
        for (int p = 0; p < NN; p++) exp_v[p] = (2 * (p % 100) > 127) ? 127 : 2 * (p % 100);
        send_matrix(0, 99);
        send_kernel(0, 4);
        send_matrix(100, NN - 1);
        collect("reload_x2", -1);
        kmod[8] = 1;
        for (int x = 0; x < NN; x++) mmod[x] = (x % 7) - 3;
        send_kernel(5, 8);
        send_matrix(0, NN - 1);
        fill_model();
        collect("reload_tail", -1);
    endtask

    task automatic test_reset_mid();
        bit quiet;
        send_matrix(0, NN - 1);
        step();
        step();
        step();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_compute got busy=%b out_valid=%b required 1 0", busy, out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, out_last, done, busy} !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b required 0", {in_ready, out_valid, out_data, out_last, done, busy});
        end
        step();
        step();
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL mid_reset_quiet got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        for (int p = 0; p < NN; p++) exp_v[p] = 0;
        send_matrix(0, NN - 1);
        collect("zeroed_kernel", -1);
        for (int k = 0; k < KK; k++) kmod[k] = 0;
        kmod[4] = 1;
        kmod[8] = -1;
        send_kernel(0, 8);
        send_matrix(0, NN - 1);
        fill_model();
        collect("after_reset", -1);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_ones();
        test_saturation();
        test_backpressure();
        test_kernel_reload();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
